gf2m_mul_serial: RTL



---
 rtl/gf2m_pkg.sv | 33 +++
 rtl/gf2m_mul_serial_if.sv | 24 ++
 rtl/gf2m_mac_step.sv | 15 +
 rtl/gf2m_mul_serial.sv | 128 ++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) field definitions for the trinomial x^N + x^K + 1.
// Used by the serial multiplier and the upstream inverter.
package gf2m_pkg;

    localparam int GF_N    = 5;
    localparam int GF_K    = 2;
    localparam int GF_MAXW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x, then reduce the x^n term to x^k + 1.
    // Operands are carried zero-extended to GF_MAXW bits so that one function
    // serves every field size below that width.
    function automatic logic [GF_MAXW-1:0] xtime(
        input logic [GF_MAXW-1:0] p,
        input int                 n = GF_N,
        input int                 k = GF_K
    );
        logic [GF_MAXW-1:0] mask;
        logic [GF_MAXW-1:0] r;
        mask = (GF_MAXW'(1) << n) - GF_MAXW'(1);
        r    = (p << 1) & mask;
        if (((p >> (n - 1)) & GF_MAXW'(1)) != '0) begin
            r = r ^ GF_MAXW'(1) ^ (GF_MAXW'(1) << k);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2m_mul_serial_if.sv
// Operand/result bundle between the field inverter and the serial multiplier.
interface gf2m_mul_serial_if
    import gf2m_pkg::*;
#(
    parameter int N = GF_N
);
    logic         IN_VALID;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         IN_READY;
    logic [N-1:0] OUT;
    logic         OUT_VALID;
    logic         BUSY;

    modport master (
        output IN_VALID, A, B,
        input  IN_READY, OUT, OUT_VALID, BUSY
    );

    modport slave (
        input  IN_VALID, A, B,
        output IN_READY, OUT, OUT_VALID, BUSY
    );
endinterface

// File: rtl/gf2m_mac_step.sv
// One MSB-first shift-and-add step: res = xtime(acc) ^ (bit_in ? a : 0).
// Purely combinational.
module gf2m_mac_step
    import gf2m_pkg::*;
#(
    parameter int N = GF_N,
    parameter int K = GF_K
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] a,
    input  logic         bit_in,
    output logic [N-1:0] res
);
    assign res = N'(xtime(GF_MAXW'(acc), N, K)) ^ (bit_in ? a : '0);
endmodule

// File: rtl/gf2m_mul_serial.sv
// Bit-serial GF(2^N) multiplier, OUT = A*B mod (x^N + x^K + 1); one op in flight.
// Latency N cycles (ceil(N/2) with GF_MUL_DIGIT2_EN); strobes while busy are dropped.
module gf2m_mul_serial
    import gf2m_pkg::*;
#(
    parameter int N = GF_N,
    parameter int K = GF_K
) (
    input  logic               CLK,
    input  logic               RST_N,
    gf2m_mul_serial_if.slave   bus
);
    if (K < 1 || K >= N) begin : g_bad_k
        $fatal(1, "gf2m_mul_serial: K must satisfy 0 < K < N");
    end
    if (N < 2 || N >= GF_MAXW) begin : g_bad_n
        $fatal(1, "gf2m_mul_serial: N out of supported range");
    end

`ifdef GF_MUL_DIGIT2_EN
    localparam int CW = $clog2(N + 1);
    // Odd N starts on the zero-padded virtual bit b[N].
    localparam logic [CW-1:0] CNT_START = CW'((N % 2 == 1) ? N : N - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(2);
`else
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_START = CW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST  = '0;
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);
`endif

    state_t        state;
    logic [N-1:0]  acc;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [CW-1:0] cnt;
    logic          in_valid_q;
    logic [N-1:0]  out_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          busy_q;
    logic [N-1:0]  acc_nxt;

`ifdef GF_MUL_DIGIT2_EN
    logic [N:0]    b_pad;
    logic [N-1:0]  acc_mid;
    logic [CW-1:0] cnt_lo;

    assign b_pad  = {1'b0, b_q};
    assign cnt_lo = cnt - CW'(1);

    gf2m_mac_step #(.N(N), .K(K)) u_step_hi (
        .acc    (acc),
        .a      (a_q),
        .bit_in (b_pad[cnt]),
        .res    (acc_mid)
    );

    gf2m_mac_step #(.N(N), .K(K)) u_step_lo (
        .acc    (acc_mid),
        .a      (a_q),
        .bit_in (b_pad[cnt_lo]),
        .res    (acc_nxt)
    );
`else
    gf2m_mac_step #(.N(N), .K(K)) u_step (
        .acc    (acc),
        .a      (a_q),
        .bit_in (b_q[cnt]),
        .res    (acc_nxt)
    );
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            acc         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            in_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            // Edge detect runs in every state so a held level never re-triggers.
            in_valid_q <= bus.IN_VALID;
            case (state)
                IDLE: begin
                    if (bus.IN_VALID && !in_valid_q) begin
                        a_q        <= bus.A;
                        b_q        <= bus.B;
                        acc        <= '0;
                        cnt        <= CNT_START;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CNT_STEP;
                    if (cnt == CNT_LAST) begin
                        out_q       <= acc_nxt;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.OUT       = out_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.IN_READY  = in_ready_q;
    assign bus.BUSY      = busy_q;
endmodule
